sbqm_queue_ctrl: RTL

Queue controller for the smart bank queue manager: debounces the entry (back) and exit (front) photo-sensors, maintains the 3-bit people count and the registered teller count, and sequences the waiting-time lookup ROM. It drives the ROM address `{tcount, pcount}`, registers the returned waiting time, and raises full, empty and error indications for the display and alarm logic.

---
 rtl/sbqm_queue_ctrl.sv | 133 +++++++++++++
 1 files changed

// File: rtl/sbqm_queue_ctrl.sv
// Queue controller for the smart bank queue manager: debounced entry/exit sensing,
// people/teller counts, and waiting-time ROM sequencing with error/flag outputs.
module sbqm_queue_ctrl #(
    parameter int unsigned DEBOUNCE = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       back_sensor,
    input  logic       front_sensor,
    input  logic [1:0] tcount_in,
    input  logic [7:0] rom_data,
    output logic [4:0] rom_addr,
    output logic [2:0] pcount,
    output logic [1:0] tcount,
    output logic       empty_flag,
    output logic       full_flag,
    output logic [7:0] wait_time,
    output logic       wait_valid,
    output logic       overflow_err,
    output logic       underflow_err
);

    typedef enum logic [1:0] {S_EMPTY, S_QUEUED, S_FULL} state_t;

    state_t     state, state_nxt;
    logic [2:0] pcount_nxt;
    logic       ovf_nxt, unf_nxt;
    logic       addr_chg;
    logic [1:0] raw;
    logic [1:0] ev;
    logic       inc, dec;

    assign raw = {front_sensor, back_sensor};

    // Index 0 is the entry (back) sensor, index 1 the exit (front) sensor.
    for (genvar g = 0; g < 2; g++) begin : g_deb
        logic       s1, s2, lvl, lvl_d;
        logic [3:0] cnt;

        always_ff @(posedge clk) begin
            if (rst) begin
                s1    <= 1'b0;
                s2    <= 1'b0;
                lvl   <= 1'b0;
                lvl_d <= 1'b0;
                cnt   <= '0;
            end else begin
                s1    <= raw[g];
                s2    <= s1;
                lvl_d <= lvl;
                if (s2 == lvl) begin
                    cnt <= '0;
                end else if (cnt == 4'(DEBOUNCE)) begin
                    lvl <= s2;
                    cnt <= '0;
                end else begin
                    cnt <= cnt + 4'd1;
                end
            end
        end

        assign ev[g] = lvl & ~lvl_d;
    end

    // Simultaneous entry and exit cancel out, so only lone events move the count.
    assign inc = ev[0] & ~ev[1];
    assign dec = ev[1] & ~ev[0];

    always_comb begin
        state_nxt  = state;
        pcount_nxt = pcount;
        ovf_nxt    = 1'b0;
        unf_nxt    = 1'b0;
        case (state)
            S_EMPTY: begin
                if (inc) begin
                    state_nxt  = S_QUEUED;
                    pcount_nxt = 3'd1;
                end else if (dec) begin
                    unf_nxt = 1'b1;
                end
            end
            S_QUEUED: begin
                if (inc) begin
                    pcount_nxt = pcount + 3'd1;
                    if (pcount == 3'd6) state_nxt = S_FULL;
                end else if (dec) begin
                    pcount_nxt = pcount - 3'd1;
                    if (pcount == 3'd1) state_nxt = S_EMPTY;
                end
            end
            S_FULL: begin
                if (inc) begin
                    ovf_nxt = 1'b1;
                end else if (dec) begin
                    state_nxt  = S_QUEUED;
                    pcount_nxt = 3'd6;
                end
            end
            default: begin
                state_nxt  = S_EMPTY;
                pcount_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_EMPTY;
            pcount        <= '0;
            tcount        <= '0;
            wait_time     <= '0;
            addr_chg      <= 1'b0;
            wait_valid    <= 1'b0;
            overflow_err  <= 1'b0;
            underflow_err <= 1'b0;
        end else begin
            state         <= state_nxt;
            pcount        <= pcount_nxt;
            tcount        <= tcount_in;
            wait_time     <= rom_data;
            addr_chg      <= (pcount_nxt != pcount) || (tcount_in != tcount);
            wait_valid    <= addr_chg;
            overflow_err  <= ovf_nxt;
            underflow_err <= unf_nxt;
        end
    end

    assign rom_addr   = {tcount, pcount};
    assign empty_flag = (state == S_EMPTY);
    assign full_flag  = (state == S_FULL);

endmodule
